codec_stream_ctrl: RTL and testbench
====================================

// Module: codec_stream_ctrl
// PURPOSE
//  Sequences sample flow between the codec serializer and the DSP fabric. Frames the codec's
//  per-sample update strobe, buffers ADC stereo samples into a capture FIFO (valid/ready out),
//  buffers playback samples from a producer (valid/ready in), presents one DAC pair per frame.
//  Holds streams off for a settle period after enable so post-PDN garbage never reaches DSP.
// PARAMETERS
//  CAP_DEPTH      4   capture FIFO depth in stereo pairs; power of 2, >=2
//  PLAY_DEPTH     4   playback FIFO depth in stereo pairs; power of 2, >=2
//  SETTLE_FRAMES  64  frames discarded after enable before RUN; 1..255
//  UNDERRUN_HOLD  0   1: repeat last DAC pair on underrun; 0: output zero
// PORTS
//  clk          in   1   system clock (same clock as the codec block)
//  rst          in   1   synchronous, active-high reset
//  enable       in   1   level; 1 = stream, 0 = stop and flush
//  adc_update   in   1   codec ADC update strobe; may stay high several clk cycles
//  lch_adc      in   24  codec left ADC sample, left adjusted
//  rch_adc      in   24  codec right ADC sample, left adjusted
//  lch_dac      out  24  left DAC sample to codec, right adjusted
//  rch_dac      out  24  right DAC sample to codec, right adjusted
//  cap_valid    out  1   capture FIFO head valid
//  cap_ready    in   1   consumer accepts head
//  cap_left     out  24  capture head, left
//  cap_right    out  24  capture head, right
//  play_valid   in   1   producer offers pair
//  play_ready   out  1   playback FIFO accepts pair
//  play_left    in   24  offered pair, left
//  play_right   in   24  offered pair, right
//  running      out  1   1 while state == RUN
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; FIFOs empty; settle counter 0; edge register 0.
//  Frame event: adc_update high AND registered previous value low; asserted 1 cycle after rise.
//  One frame event per strobe regardless of strobe length.
//  FSM:
//   IDLE   : play_ready=0, cap_valid=0, DAC outs 0, FIFOs flushed. enable=1 -> SETTLE, cnt=0.
//   SETTLE : count frame events; after SETTLE_FRAMES-th -> RUN. play_ready=!play_full (prefill
//            allowed). No capture pushes. DAC outs held 0.
//   RUN    : running=1. Each frame event: push {lch_adc,rch_adc} to capture FIFO, pop playback
//            FIFO into lch_dac/rch_dac (registered, visible the cycle after the frame event).
//   Any state: enable=0 -> IDLE next cycle; FIFOs flushed, in-flight pairs dropped, outs 0.
//  Capture FIFO: first-word-fall-through; pop on cap_valid&cap_ready. Full at frame event ->
//   new pair dropped (overrun), contents unchanged. Full + pop + frame same cycle -> push accepted.
//  Playback FIFO: push on play_valid&play_ready. Empty at frame event -> underrun: DAC outs
//   = last pair (UNDERRUN_HOLD=1) or 0 (UNDERRUN_HOLD=0). Push into empty FIFO in the frame-event
//   cycle is stored; that frame still underruns.
//  Pointers wrap modulo depth; occupancy counter is log2(depth)+1 bits; no width truncation.
//  Sample widths pass through unchanged; block does no scaling.
//  rst mid-operation overrides enable; everything returns to reset values next cycle.
// CONFIGURATION
//  CODEC_STREAM_STATUS_EN defined: adds ports status_clr (in,1), overrun_cnt (out,16),
//   underrun_cnt (out,16). Counts +1 per overrun/underrun event in RUN, saturate at 16'hFFFF,
//   zero on rst or status_clr (clear wins over same-cycle increment). Not cleared by enable=0.
//  Not defined: ports absent; no counters synthesized; all other behaviour identical.
// TESTING
//  1) enable=1, SETTLE_FRAMES=4, 6 strobes, ADC=0x123456/0xABCDEF -> running after strobe 4,
//     exactly 2 pairs in capture FIFO, both 0x123456/0xABCDEF.
//  2) adc_update held high 6 cycles per strobe -> exactly one push/pop per strobe.
//  3) RUN, cap_ready=0, 6 frames, CAP_DEPTH=4 -> 4 oldest pairs retained, 2 dropped;
//     overrun_cnt=2 with macro.
//  4) RUN, push pair 0x000001/0x000002, then 2 frames with no more pushes -> frame1 DAC =
//     0x000001/0x000002; frame2 DAC = same (HOLD=1) or 0/0 (HOLD=0); underrun_cnt=1.
//  5) Capture full, cap_ready=1 and frame event in same cycle -> new pair accepted, count stays 4.
//  6) enable dropped mid-RUN with both FIFOs non-empty -> next cycle IDLE, cap_valid=0,
//     play_ready=0, DAC outs 0; re-enable requires a full settle again.

Source files
------------

// File: rtl/codec_stream_if.sv
// codec_stream_if: capture (valid/ready out) and playback (valid/ready in) stereo streams
// master: codec_stream_ctrl side (drives cap_valid/cap_left/cap_right/play_ready)
// slave : DSP fabric side (drives cap_ready/play_valid/play_left/play_right)
interface codec_stream_if #(parameter int W = 24);
  logic         cap_valid;
  logic         cap_ready;
  logic [W-1:0] cap_left;
  logic [W-1:0] cap_right;
  logic         play_valid;
  logic         play_ready;
  logic [W-1:0] play_left;
  logic [W-1:0] play_right;
  modport master (
    output cap_valid, cap_left, cap_right, play_ready,
    input  cap_ready, play_valid, play_left, play_right
  );
  modport slave (
    input  cap_valid, cap_left, cap_right, play_ready,
    output cap_ready, play_valid, play_left, play_right
  );
endinterface

// File: rtl/codec_stream_ctrl.sv
// codec_stream_ctrl: frames codec update strobes, buffers ADC capture and DAC playback pairs
// Ports: clk, rst (sync, active high), enable (level), adc_update (codec strobe),
//   lch_adc/rch_adc (ADC pair in), lch_dac/rch_dac (DAC pair out), running (state RUN),
//   s (codec_stream_if.master: capture stream out, playback stream in).
// Optional feature macro CODEC_STREAM_STATUS_EN adds status_clr, overrun_cnt, underrun_cnt.
module codec_stream_ctrl #(
  parameter int CAP_DEPTH     = 4,
  parameter int PLAY_DEPTH    = 4,
  parameter int SETTLE_FRAMES = 64,
  parameter int UNDERRUN_HOLD = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        adc_update,
  input  logic [23:0] lch_adc,
  input  logic [23:0] rch_adc,
  output logic [23:0] lch_dac,
  output logic [23:0] rch_dac,
  output logic        running,
`ifdef CODEC_STREAM_STATUS_EN
  input  logic        status_clr,
  output logic [15:0] overrun_cnt,
  output logic [15:0] underrun_cnt,
`endif
  codec_stream_if.master s
);
  localparam int CAW = $clog2(CAP_DEPTH);
  localparam int CCW = CAW + 1;
  localparam int PAW = $clog2(PLAY_DEPTH);
  localparam int PCW = PAW + 1;
  typedef enum logic [1:0] {IDLE, SETTLE, RUN} state_t;
  state_t state_q, state_d;
  logic adc_prev_q, adc_prev_d;
  logic frame_q, frame_d;
  logic [7:0] settle_q, settle_d;
  logic [47:0] cap_mem_q [CAP_DEPTH];
  logic [47:0] cap_mem_d [CAP_DEPTH];
  logic [CAW-1:0] cap_wp_q, cap_wp_d, cap_rp_q, cap_rp_d;
  logic [CCW-1:0] cap_cnt_q, cap_cnt_d;
  logic [47:0] play_mem_q [PLAY_DEPTH];
  logic [47:0] play_mem_d [PLAY_DEPTH];
  logic [PAW-1:0] play_wp_q, play_wp_d, play_rp_q, play_rp_d;
  logic [PCW-1:0] play_cnt_q, play_cnt_d;
  logic [47:0] dac_q, dac_d;
  logic run, cap_full, play_full, cap_pop, cap_push, play_push, play_pop, underrun;
  assign run       = state_q == RUN;
  assign cap_full  = cap_cnt_q == CCW'(CAP_DEPTH);
  assign play_full = play_cnt_q == PCW'(PLAY_DEPTH);
  assign cap_pop   = s.cap_valid & s.cap_ready;
  // a pop on the same edge frees the slot, so a full FIFO still accepts the new pair
  assign cap_push  = run & frame_q & (~cap_full | cap_pop);
  assign play_push = s.play_valid & s.play_ready;
  // decided on pre-push occupancy: a pair arriving in the frame cycle waits for the next frame
  assign play_pop  = run & frame_q & (play_cnt_q != '0);
  assign underrun  = run & frame_q & (play_cnt_q == '0);
  assign running      = run;
  assign lch_dac      = dac_q[47:24];
  assign rch_dac      = dac_q[23:0];
  assign s.cap_valid  = cap_cnt_q != '0;
  assign s.cap_left   = s.cap_valid ? cap_mem_q[cap_rp_q][47:24] : '0;
  assign s.cap_right  = s.cap_valid ? cap_mem_q[cap_rp_q][23:0] : '0;
  assign s.play_ready = (state_q != IDLE) & ~play_full;
  always_comb begin
    state_d    = state_q;
    settle_d   = settle_q;
    adc_prev_d = adc_update;
    frame_d    = adc_update & ~adc_prev_q;
    cap_mem_d  = cap_mem_q;
    play_mem_d = play_mem_q;
    cap_wp_d   = cap_wp_q + CAW'(cap_push);
    cap_rp_d   = cap_rp_q + CAW'(cap_pop);
    cap_cnt_d  = cap_cnt_q + CCW'(cap_push) - CCW'(cap_pop);
    play_wp_d  = play_wp_q + PAW'(play_push);
    play_rp_d  = play_rp_q + PAW'(play_pop);
    play_cnt_d = play_cnt_q + PCW'(play_push) - PCW'(play_pop);
    dac_d      = play_pop ? play_mem_q[play_rp_q] : (underrun && UNDERRUN_HOLD == 0) ? '0 : dac_q;
    if (cap_push) cap_mem_d[cap_wp_q] = {lch_adc, rch_adc};
    if (play_push) play_mem_d[play_wp_q] = {s.play_left, s.play_right};
    if (state_q == IDLE) begin
      state_d  = SETTLE;
      settle_d = '0;
    end
    if (state_q == SETTLE && frame_q) begin
      settle_d = settle_q + 8'd1;
      state_d  = settle_q == 8'(SETTLE_FRAMES - 1) ? RUN : SETTLE;
    end
    // stop: drop everything buffered or in flight and silence the DAC
    if (!enable) begin
      state_d    = IDLE;
      settle_d   = '0;
      cap_wp_d   = '0;
      cap_rp_d   = '0;
      cap_cnt_d  = '0;
      play_wp_d  = '0;
      play_rp_d  = '0;
      play_cnt_d = '0;
      dac_d      = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      settle_q   <= '0;
      adc_prev_q <= 1'b0;
      frame_q    <= 1'b0;
      cap_mem_q  <= '{default: '0};
      play_mem_q <= '{default: '0};
      cap_wp_q   <= '0;
      cap_rp_q   <= '0;
      cap_cnt_q  <= '0;
      play_wp_q  <= '0;
      play_rp_q  <= '0;
      play_cnt_q <= '0;
      dac_q      <= '0;
    end else begin
      state_q    <= state_d;
      settle_q   <= settle_d;
      adc_prev_q <= adc_prev_d;
      frame_q    <= frame_d;
      cap_mem_q  <= cap_mem_d;
      play_mem_q <= play_mem_d;
      cap_wp_q   <= cap_wp_d;
      cap_rp_q   <= cap_rp_d;
      cap_cnt_q  <= cap_cnt_d;
      play_wp_q  <= play_wp_d;
      play_rp_q  <= play_rp_d;
      play_cnt_q <= play_cnt_d;
      dac_q      <= dac_d;
    end
  end
`ifdef CODEC_STREAM_STATUS_EN
  logic overrun;
  logic [15:0] ovr_q, ovr_d, und_q, und_d;
  assign overrun = run & frame_q & cap_full & ~cap_pop;
  always_comb begin
    ovr_d = status_clr ? '0 : ovr_q + 16'(overrun && ovr_q != '1);
    und_d = status_clr ? '0 : und_q + 16'(underrun && und_q != '1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ovr_q <= '0;
      und_q <= '0;
    end else begin
      ovr_q <= ovr_d;
      und_q <= und_d;
    end
  end
  assign overrun_cnt  = ovr_q;
  assign underrun_cnt = und_q;
`endif
endmodule

// File: tb/tb_codec_stream_ctrl.sv
// tb_codec_stream_ctrl: randomized scoreboard bench for codec_stream_ctrl against a queue model
module tb_codec_stream_ctrl;
  localparam int CD = 4, PD = 4, SF = 4, HOLD = 1;
  typedef logic [47:0] pair_t;
  logic clk = 0, rst = 1, enable = 0, adc_update = 0;
  logic [23:0] lch_adc = 0, rch_adc = 0;
  logic [23:0] lch_dac, rch_dac;
  logic running;
`ifdef CODEC_STREAM_STATUS_EN
  logic status_clr = 0;
  logic [15:0] overrun_cnt, underrun_cnt;
  int m_ovr = 0, m_und = 0;
`endif
  codec_stream_if bus ();
  codec_stream_ctrl #(.CAP_DEPTH(CD), .PLAY_DEPTH(PD), .SETTLE_FRAMES(SF), .UNDERRUN_HOLD(HOLD)) dut (
    .clk(clk), .rst(rst), .enable(enable), .adc_update(adc_update),
    .lch_adc(lch_adc), .rch_adc(rch_adc), .lch_dac(lch_dac), .rch_dac(rch_dac),
    .running(running),
`ifdef CODEC_STREAM_STATUS_EN
    .status_clr(status_clr), .overrun_cnt(overrun_cnt), .underrun_cnt(underrun_cnt),
`endif
    .s(bus)
  );
  always #5 clk = ~clk;
  int nvec = 0, errs = 0;
  bit rand_mode = 0;
  int rdy_pct = 50, val_pct = 50;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask
  // Reference model: FIFOs as queues, settle as a frame count since enable
  pair_t m_cap[$], m_play[$], exp_cap[$];
  pair_t m_dac = 0;
  bit m_en = 0, m_prev = 0, m_fe = 0;
  int m_frames = 0;
  bit fe, pop, push, run, full, ovr_ev, und_ev;
  always @(posedge clk) begin
    fe = m_fe;
    pop = bus.cap_ready && m_cap.size() != 0;
    push = bus.play_valid && m_en && m_play.size() < PD;
    run = m_en && m_frames >= SF;
    full = m_cap.size() == CD;
    ovr_ev = 0;
    und_ev = 0;
    if (rst) begin
      m_fe = 0; m_prev = 0; m_en = 0; m_frames = 0; m_dac = 0;
      m_cap.delete(); m_play.delete(); exp_cap.delete();
`ifdef CODEC_STREAM_STATUS_EN
      m_ovr = 0; m_und = 0;
`endif
    end else begin
      m_fe = adc_update && !m_prev;
      m_prev = adc_update;
      if (!enable) begin
        m_en = 0; m_frames = 0; m_dac = 0;
        m_cap.delete(); m_play.delete(); exp_cap.delete();
      end else if (!m_en) begin
        m_en = 1; m_frames = 0;
      end else begin
        if (pop) void'(m_cap.pop_front());
        if (fe && run) begin
          if (!full || pop) begin
            m_cap.push_back({lch_adc, rch_adc});
            exp_cap.push_back({lch_adc, rch_adc});
          end else ovr_ev = 1;
          if (m_play.size() != 0) m_dac = m_play.pop_front();
          else begin
            if (HOLD == 0) m_dac = 0;
            und_ev = 1;
          end
        end
        if (push) m_play.push_back({bus.play_left, bus.play_right});
        if (fe && !run) m_frames++;
      end
`ifdef CODEC_STREAM_STATUS_EN
      m_ovr = status_clr ? 0 : (ovr_ev && m_ovr < 65535) ? m_ovr + 1 : m_ovr;
      m_und = status_clr ? 0 : (und_ev && m_und < 65535) ? m_und + 1 : m_und;
`endif
    end
  end
  // Monitor: mid-cycle compare of outputs; capture pairs popped from the scoreboard on handshake
  always @(negedge clk) begin
    chk("running", running, m_en && m_frames >= SF);
    chk("play_ready", bus.play_ready, m_en && m_play.size() < PD);
    chk("cap_valid", bus.cap_valid, m_cap.size() != 0);
    chk("dac", {lch_dac, rch_dac}, m_dac);
`ifdef CODEC_STREAM_STATUS_EN
    chk("overrun_cnt", overrun_cnt, m_ovr);
    chk("underrun_cnt", underrun_cnt, m_und);
`endif
    if (bus.cap_valid && bus.cap_ready) begin
      if (exp_cap.size() == 0) begin
        nvec++;
        errs++;
        $display("FAIL cap_extra: got %h want no pair at %0t", {bus.cap_left, bus.cap_right}, $time);
      end else chk("cap_data", {bus.cap_left, bus.cap_right}, exp_cap.pop_front());
    end
  end
  task automatic tick();
    @(posedge clk);
    #2;
    if (rand_mode) begin
      bus.cap_ready = $urandom_range(0, 99) < rdy_pct;
      bus.play_valid = $urandom_range(0, 99) < val_pct;
      bus.play_left = 24'($urandom);
      bus.play_right = 24'($urandom);
`ifdef CODEC_STREAM_STATUS_EN
      status_clr = $urandom_range(0, 63) == 0;
`endif
    end
  endtask
  task automatic strobe(input int len, input int gap, input bit rdy_at_frame = 0);
    adc_update = 1;
    for (int i = 0; i < len; i++) begin
      tick();
      if (rdy_at_frame && i == 0) bus.cap_ready = 1;
      if (rdy_at_frame && i == 1) bus.cap_ready = 0;
    end
    adc_update = 0;
    for (int i = 0; i < gap; i++) tick();
  endtask
  task automatic set_adc(input logic [23:0] l, input logic [23:0] r);
    lch_adc = l;
    rch_adc = r;
  endtask
`ifdef CODEC_STREAM_STATUS_EN
  task automatic clr_status();
    status_clr = 1;
    tick();
    status_clr = 0;
  endtask
`endif
  initial begin
    bus.cap_ready = 0;
    bus.play_valid = 0;
    bus.play_left = 0;
    bus.play_right = 0;
    repeat (3) tick();
    rst = 0;
    chk("rst_running", running, 0);
    chk("rst_cap_valid", bus.cap_valid, 0);
    chk("rst_play_ready", bus.play_ready, 0);
    chk("rst_dac", {lch_dac, rch_dac}, 0);
    enable = 1;
    tick();
    set_adc(24'h123456, 24'hABCDEF);
    for (int i = 1; i <= 6; i++) begin
      strobe(i % 2 == 1 ? 1 : 6, 4);
      if (i == 3) chk("t1_settling", running, 0);
      if (i == 4) chk("t1_running", running, 1);
    end
    chk("t1_head0", {bus.cap_left, bus.cap_right}, 48'h123456ABCDEF);
    bus.cap_ready = 1;
    tick();
    chk("t1_head1", {bus.cap_left, bus.cap_right}, 48'h123456ABCDEF);
    tick();
    bus.cap_ready = 0;
    chk("t1_two_pairs", bus.cap_valid, 0);
`ifdef CODEC_STREAM_STATUS_EN
    clr_status();
`endif
    for (int i = 1; i <= 6; i++) begin
      set_adc(24'(i), 24'(i + 100));
      strobe(2, 3);
    end
`ifdef CODEC_STREAM_STATUS_EN
    chk("t3_overrun_cnt", overrun_cnt, 2);
`endif
    for (int i = 1; i <= 4; i++) begin
      chk("t3_keep", {bus.cap_left, bus.cap_right}, {24'(i), 24'(i + 100)});
      bus.cap_ready = 1;
      tick();
      bus.cap_ready = 0;
    end
    chk("t3_dropped", bus.cap_valid, 0);
`ifdef CODEC_STREAM_STATUS_EN
    clr_status();
`endif
    bus.play_valid = 1;
    bus.play_left = 24'h000001;
    bus.play_right = 24'h000002;
    tick();
    bus.play_valid = 0;
    set_adc(24'h400001, 24'h400002);
    strobe(2, 3);
    chk("t4_frame1_dac", {lch_dac, rch_dac}, 48'h000001000002);
    strobe(2, 3);
    chk("t4_frame2_dac", {lch_dac, rch_dac}, HOLD ? 48'h000001000002 : 48'h0);
`ifdef CODEC_STREAM_STATUS_EN
    chk("t4_underrun_cnt", underrun_cnt, 1);
`endif
    set_adc(24'h500001, 24'h500002);
    strobe(2, 3);
    strobe(2, 3);
    set_adc(24'h777777, 24'h888888);
    strobe(3, 3, 1);
    bus.cap_ready = 1;
    repeat (3) tick();
    bus.cap_ready = 0;
    chk("t5_accepted", {bus.cap_left, bus.cap_right}, 48'h777777888888);
    bus.cap_ready = 1;
    tick();
    bus.cap_ready = 0;
    chk("t5_count4", bus.cap_valid, 0);
`ifdef CODEC_STREAM_STATUS_EN
    chk("t5_no_overrun", overrun_cnt, 0);
`endif
    bus.play_valid = 1;
    bus.play_left = 24'h0A0A0A;
    bus.play_right = 24'h0B0B0B;
    repeat (2) tick();
    bus.play_valid = 0;
    strobe(1, 3);
    enable = 0;
    tick();
    chk("t6_running", running, 0);
    chk("t6_cap_valid", bus.cap_valid, 0);
    chk("t6_play_ready", bus.play_ready, 0);
    chk("t6_dac", {lch_dac, rch_dac}, 0);
    enable = 1;
    tick();
    for (int i = 0; i < SF - 1; i++) strobe(2, 3);
    chk("t6_resettle", running, 0);
    strobe(2, 3);
    chk("t6_rerun", running, 1);
    rand_mode = 1;
    for (int it = 0; it < 260; it++) begin
      if (it % 40 == 0) begin
        rdy_pct = $urandom_range(5, 95);
        val_pct = $urandom_range(5, 95);
      end
      set_adc(24'($urandom), 24'($urandom));
      strobe($urandom_range(1, 6), $urandom_range(2, 8));
      if ($urandom_range(0, 24) == 0) begin
        enable = 0;
        repeat ($urandom_range(1, 3)) tick();
        enable = 1;
      end
      if (it == 150) begin
        rst = 1;
        tick();
        rst = 0;
        chk("rst_mid_running", running, 0);
        chk("rst_mid_cap_valid", bus.cap_valid, 0);
      end
    end
    rand_mode = 0;
`ifdef CODEC_STREAM_STATUS_EN
    status_clr = 0;
`endif
    bus.play_valid = 0;
    bus.cap_ready = 1;
    repeat (8) tick();
    chk("end_drained", exp_cap.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
    $finish;
  end
endmodule
